reg_file_scoreboard: RTL and testbench

- Receiving end of the write-back interface: a 32 x 64-bit register file that accepts the write-back stage's Data2Write / Reg2Write / oldRegWrite triple.
- Serves two combinational read ports to decode.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight instructions and stall.
- Sits between decode (read, issue) and write-back (write, retire).

---
 rtl/reg_file_scoreboard_if.sv | 33 +++
 rtl/reg_file_scoreboard.sv | 117 +++++++++++
 tb/tb_reg_file_scoreboard.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back bundle for the register file: two read ports, the issue
// port that books pending writes, and the write-back triple that retires them.
interface reg_file_scoreboard_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AW     = 5
);
  logic [AW-1:0]     ReadReg1;
  logic [AW-1:0]     ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Hazard1;
  logic              Hazard2;
  logic              IssueValid;
  logic              IssueRegWrite;
  logic [AW-1:0]     IssueReg;
  logic              IssueStall;
  logic [AW-1:0]     Reg2Write;
  logic [DATA_W-1:0] Data2Write;
  logic              oldRegWrite;
  logic              ErrUnderflow;

  modport master (
    output ReadReg1, ReadReg2, IssueValid, IssueRegWrite, IssueReg,
           Reg2Write, Data2Write, oldRegWrite,
    input  ReadData1, ReadData2, Hazard1, Hazard2, IssueStall, ErrUnderflow
  );

  modport slave (
    input  ReadReg1, ReadReg2, IssueValid, IssueRegWrite, IssueReg,
           Reg2Write, Data2Write, oldRegWrite,
    output ReadData1, ReadData2, Hazard1, Hazard2, IssueStall, ErrUnderflow
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with write-through bypass and a per-register pending-write
// scoreboard used by decode for RAW hazard detection. X31 reads as zero.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned PEND_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  reg_file_scoreboard_if.slave bus
);
  localparam int unsigned    AW   = $clog2(NREG);
  localparam logic [AW-1:0]  XZR  = AW'(NREG - 1);
  localparam logic [PEND_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] regs    [NREG];
  logic [PEND_W-1:0] cnt     [NREG];
  logic [PEND_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]   inc_v;
  logic [NREG-1:0]   dec_v;
  logic issue_wr;
  logic accept;
  logic retire;
  logic underflow;
  logic err_q;

  always_comb begin
    issue_wr  = bus.IssueValid & bus.IssueRegWrite & (bus.IssueReg != XZR);
    accept    = issue_wr & (cnt[bus.IssueReg] != CMAX);
    retire    = bus.oldRegWrite & (bus.Reg2Write != XZR);
    // A same-cycle accept to the retiring register supplies the missing booking.
    underflow = retire & (cnt[bus.Reg2Write] == '0)
              & ~(accept & (bus.IssueReg == bus.Reg2Write));
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      inc_v[r] = accept & (bus.IssueReg == AW'(r));
      dec_v[r] = retire & (bus.Reg2Write == AW'(r));
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_v[r] && !dec_v[r]) begin
        cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (dec_v[r] && !inc_v[r] && (cnt[r] != '0)) begin
        cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (retire) begin
        regs[bus.Reg2Write] <= bus.Data2Write;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read ports: X31 first, then bypass of the write-back in flight this cycle.
  always_comb begin
    if (bus.ReadReg1 == XZR) begin
      bus.ReadData1 = '0;
    end else if (bus.oldRegWrite && (bus.Reg2Write == bus.ReadReg1)) begin
      bus.ReadData1 = bus.Data2Write;
    end else begin
      bus.ReadData1 = regs[bus.ReadReg1];
    end

    if (bus.ReadReg2 == XZR) begin
      bus.ReadData2 = '0;
    end else if (bus.oldRegWrite && (bus.Reg2Write == bus.ReadReg2)) begin
      bus.ReadData2 = bus.Data2Write;
    end else begin
      bus.ReadData2 = regs[bus.ReadReg2];
    end
  end

  // The retiring write is already bypassed, so it no longer counts as pending.
  always_comb begin
    bus.Hazard1 = 1'b0;
    bus.Hazard2 = 1'b0;
    if (bus.ReadReg1 != XZR) begin
      if (retire && (bus.Reg2Write == bus.ReadReg1)) begin
        bus.Hazard1 = cnt[bus.ReadReg1] > PEND_W'(1);
      end else begin
        bus.Hazard1 = cnt[bus.ReadReg1] != '0;
      end
    end
    if (bus.ReadReg2 != XZR) begin
      if (retire && (bus.Reg2Write == bus.ReadReg2)) begin
        bus.Hazard2 = cnt[bus.ReadReg2] > PEND_W'(1);
      end else begin
        bus.Hazard2 = cnt[bus.ReadReg2] != '0;
      end
    end
    bus.IssueStall   = issue_wr & (cnt[bus.IssueReg] == CMAX);
    bus.ErrUnderflow = err_q;
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: expectations are queued as each step
// is driven and checked mid-cycle, away from the rising edge.
module tb_reg_file_scoreboard;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_W(64), .AW(5)) bus ();

  reg_file_scoreboard #(.DATA_W(64), .NREG(32), .PEND_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum {S_RD1, S_RD2, S_HZ1, S_HZ2, S_STALL, S_ERR} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] D_A = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D_B = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] D_C = 64'h0F0F_0000_A5A5_0001;

  function automatic logic [63:0] observe(input sel_e s);
    case (s)
      S_RD1:   return bus.ReadData1;
      S_RD2:   return bus.ReadData2;
      S_HZ1:   return {63'd0, bus.Hazard1};
      S_HZ2:   return {63'd0, bus.Hazard2};
      S_STALL: return {63'd0, bus.IssueStall};
      default: return {63'd0, bus.ErrUnderflow};
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [63:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IssueValid    = 1'b0;
    bus.IssueRegWrite = 1'b0;
    bus.IssueReg      = '0;
    bus.oldRegWrite   = 1'b0;
    bus.Reg2Write     = '0;
    bus.Data2Write    = '0;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.IssueValid    = 1'b1;
    bus.IssueRegWrite = 1'b1;
    bus.IssueReg      = r;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    bus.oldRegWrite = 1'b1;
    bus.Reg2Write   = r;
    bus.Data2Write  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.ReadReg1 = 5'd0;
    bus.ReadReg2 = 5'd0;
    @(posedge clk);
    #1;

    // Reset state
    rst_n = 1'b1;
    bus.ReadReg1 = 5'd5;
    bus.ReadReg2 = 5'd31;
    push("rst_rd1", S_RD1, 64'd0);
    push("rst_rd2", S_RD2, 64'd0);
    push("rst_hz1", S_HZ1, 64'd0);
    push("rst_hz2", S_HZ2, 64'd0);
    push("rst_err", S_ERR, 64'd0);
    push("rst_stall", S_STALL, 64'd0);
    tick();

    // Book reg 3 so its write-back is a legal retire
    idle();
    issue(5'd3);
    tick();

    // Write with same-cycle bypass
    idle();
    wb(5'd3, D_A);
    bus.ReadReg1 = 5'd3;
    bus.ReadReg2 = 5'd5;
    push("byp_rd1", S_RD1, D_A);
    push("byp_rd2", S_RD2, 64'd0);
    tick();

    idle();
    push("arr_rd1", S_RD1, D_A);
    push("arr_hz1", S_HZ1, 64'd0);
    push("arr_err", S_ERR, 64'd0);
    tick();

    // Writes to X31 are discarded
    wb(5'd31, '1);
    bus.ReadReg1 = 5'd31;
    bus.ReadReg2 = 5'd3;
    push("x31_byp_rd1", S_RD1, 64'd0);
    push("x31_hz1", S_HZ1, 64'd0);
    push("x31_rd2", S_RD2, D_A);
    tick();

    idle();
    push("x31_rd1", S_RD1, 64'd0);
    push("x31_err", S_ERR, 64'd0);
    tick();

    // RAW on reg 7
    issue(5'd7);
    bus.ReadReg1 = 5'd7;
    push("raw_issue_hz1", S_HZ1, 64'd0);
    tick();

    idle();
    push("raw_pend_hz1", S_HZ1, 64'd1);
    tick();

    wb(5'd7, D_B);
    push("raw_ret_hz1", S_HZ1, 64'd0);
    push("raw_ret_rd1", S_RD1, D_B);
    tick();

    idle();
    push("raw_after_hz1", S_HZ1, 64'd0);
    push("raw_after_rd1", S_RD1, D_B);
    push("raw_after_err", S_ERR, 64'd0);
    tick();

    // Saturation on reg 9
    bus.ReadReg2 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      issue(5'd9);
      push("sat_issue_stall", S_STALL, 64'd0);
      tick();
    end
    issue(5'd9);
    push("sat_full_stall", S_STALL, 64'd1);
    push("sat_full_hz2", S_HZ2, 64'd1);
    tick();

    idle();
    wb(5'd9, D_C);
    push("sat_ret1_hz2", S_HZ2, 64'd1);
    push("sat_ret1_stall", S_STALL, 64'd0);
    tick();
    push("sat_ret2_hz2", S_HZ2, 64'd1);
    tick();
    push("sat_ret3_hz2", S_HZ2, 64'd0);
    push("sat_ret3_rd2", S_RD2, D_C);
    tick();

    idle();
    push("sat_done_hz2", S_HZ2, 64'd0);
    push("sat_done_err", S_ERR, 64'd0);
    issue(5'd31);
    push("x31_issue_stall", S_STALL, 64'd0);
    tick();

    // Simultaneous issue and retire on reg 4 with one pending
    idle();
    issue(5'd4);
    bus.ReadReg1 = 5'd4;
    tick();

    issue(5'd4);
    wb(5'd4, D_A);
    push("sim_hz1", S_HZ1, 64'd0);
    push("sim_rd1", S_RD1, D_A);
    tick();

    idle();
    push("sim_after_hz1", S_HZ1, 64'd1);
    push("sim_after_err", S_ERR, 64'd0);
    tick();

    wb(5'd4, D_B);
    push("sim_ret_hz1", S_HZ1, 64'd0);
    tick();

    idle();
    push("sim_clear_hz1", S_HZ1, 64'd0);
    push("sim_clear_err", S_ERR, 64'd0);
    tick();

    // Underflow on reg 12
    wb(5'd12, D_C);
    push("uf_ret_err", S_ERR, 64'd0);
    tick();

    idle();
    push("uf_set_err", S_ERR, 64'd1);
    tick();
    push("uf_sticky_err", S_ERR, 64'd1);
    tick();

    // Reset wins over a simultaneous issue and write
    rst_n = 1'b0;
    issue(5'd2);
    wb(5'd2, 64'h5555_5555_5555_5555);
    tick();

    rst_n = 1'b1;
    idle();
    bus.ReadReg1 = 5'd2;
    bus.ReadReg2 = 5'd3;
    push("rst2_err", S_ERR, 64'd0);
    push("rst2_rd1", S_RD1, 64'd0);
    push("rst2_hz1", S_HZ1, 64'd0);
    push("rst2_rd2", S_RD2, 64'd0);
    tick();

    // cnt[2] must be zero: a retire now underflows
    wb(5'd2, 64'd0);
    push("rst2_ret_err", S_ERR, 64'd0);
    tick();

    idle();
    push("rst2_cnt_err", S_ERR, 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
